// File: rtl/mc_main_ctl.sv
// Main control FSM for the multicycle MIPS subset datapath.
// Sequences fetch/decode/execute/mem/writeback with a memory-ready handshake.
module mc_main_ctl #(
   parameter logic [5:0] OP_RTYPE = 6'd0,
   parameter logic [5:0] OP_LW    = 6'd35,
   parameter logic [5:0] OP_SW    = 6'd43,
   parameter logic [5:0] OP_BEQ   = 6'd4,
   parameter logic [5:0] OP_J     = 6'd2,
   parameter logic [5:0] OP_ADDI  = 6'd8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REXEC  = 4'd6,
      S_RWB    = 4'd7,
      S_BEQEX  = 4'd8,
      S_JEX    = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11
   } state_t;

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = S_FETCH;
      illegal_d = 1'b0;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (Opcode)
               OP_LW,
               OP_SW:    state_d = S_MEMADR;
               OP_RTYPE: state_d = S_REXEC;
               OP_BEQ:   state_d = S_BEQEX;
               OP_J:     state_d = S_JEX;
               OP_ADDI:  state_d = S_IEXEC;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_REXEC:  state_d = S_RWB;
         S_IEXEC:  state_d = S_IWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Reset forces every output low, including the debug state view.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;
      state       = 4'd0;
      if (!reset) begin
         state      = state_q;
         illegal_op = illegal_q;
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_REXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            S_RWB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            S_BEQEX: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
            end
            S_JEX: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
            S_IEXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_IWB:   RegWrite = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_main_ctl.sv
// Scoreboard bench for mc_main_ctl: per-cycle stimulus and expected
// output vectors are queued together, then replayed and compared.
module tb_mc_main_ctl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] Opcode = 6'd0;
   logic       mem_ready = 1'b1;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   mc_main_ctl dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic [5:0] op;
      logic       rdy;
   } stim_t;

   stim_t       sq[$];
   logic [20:0] eq[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   wire [20:0] obs = {state, PCWrite, PCWriteCond, IorD, MemRead,
                      MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                      ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

   task automatic chk(input string tag, input logic [20:0] o,
                      input logic [20:0] e);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, o, e);
      end
   endtask

   // Expected outputs straight from the state table.
   function automatic logic [20:0] exp_vec(input logic rst,
         input logic [3:0] s, input logic rdy, input logic ill);
      logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
      logic [1:0] sb, aop, psrc;
      {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
      sb = 2'b00; aop = 2'b00; psrc = 2'b00;
      if (rst) return '0;
      case (s)
         4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
         4'd1:  sb = 2'b11;
         4'd2:  begin sa = 1; sb = 2'b10; end
         4'd3:  begin mr = 1; iod = 1; end
         4'd4:  begin rw = 1; m2r = 1; end
         4'd5:  begin mw = 1; iod = 1; end
         4'd6:  begin sa = 1; aop = 2'b10; end
         4'd7:  begin rw = 1; rd = 1; end
         4'd8:  begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
         4'd9:  begin pw = 1; psrc = 2'b10; end
         4'd10: begin sa = 1; sb = 2'b10; end
         4'd11: rw = 1;
         default: ;
      endcase
      return {s, pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa,
              sb, aop, psrc, ill};
   endfunction

   task automatic step(input logic rst, input logic [5:0] op,
                       input logic rdy, input logic [3:0] s,
                       input logic ill = 1'b0);
      sq.push_back('{rst: rst, op: op, rdy: rdy});
      eq.push_back(exp_vec(rst, s, rdy, ill));
   endtask

   initial begin
      stim_t       st;
      logic [20:0] ev;

      step(1, 6'd0, 1, 0);
      // R-type
      step(0, 6'd0, 1, 0); step(0, 6'd0, 1, 1);
      step(0, 6'd0, 1, 6); step(0, 6'd0, 1, 7);
      // lw with three wait cycles; opcode churn in MEMRD is ignored
      step(0, 6'd35, 1, 0); step(0, 6'd35, 1, 1);
      step(0, 6'd35, 1, 2); step(0, 6'd43, 0, 3);
      step(0, 6'd4, 0, 3);  step(0, 6'd0, 0, 3);
      step(0, 6'd35, 1, 3); step(0, 6'd35, 1, 4);
      // sw
      step(0, 6'd43, 1, 0); step(0, 6'd43, 1, 1);
      step(0, 6'd43, 1, 2); step(0, 6'd43, 1, 5);
      // beq
      step(0, 6'd4, 1, 0); step(0, 6'd4, 1, 1); step(0, 6'd4, 1, 8);
      // illegal opcode, then pulse must clear while stalled in FETCH
      step(0, 6'h3F, 1, 0); step(0, 6'h3F, 1, 1);
      step(0, 6'h3F, 0, 0, 1); step(0, 6'h3F, 0, 0);
      // addi with mem_ready low where it must be ignored
      step(0, 6'd8, 1, 0); step(0, 6'd8, 0, 1);
      step(0, 6'd8, 0, 10); step(0, 6'd8, 0, 11);
      // j
      step(0, 6'd2, 1, 0); step(0, 6'd2, 1, 1); step(0, 6'd2, 1, 9);
      // reset while waiting in MEMWR
      step(0, 6'd43, 1, 0); step(0, 6'd43, 1, 1);
      step(0, 6'd43, 0, 2); step(0, 6'd43, 0, 5);
      step(1, 6'd43, 1, 5); step(0, 6'd43, 0, 0);
      // fetch stall of two cycles, then jump
      step(0, 6'd2, 0, 0); step(0, 6'd2, 1, 0);
      step(0, 6'd2, 1, 1); step(0, 6'd2, 1, 9);
      step(0, 6'd0, 1, 0);

      while (sq.size() > 0) begin
         @(negedge clk);
         st = sq.pop_front();
         reset = st.rst;
         Opcode = st.op;
         mem_ready = st.rdy;
         #1;
         if (eq.size() == 0) begin
            chk("sb_underflow", obs, 21'h1FFFFF);
         end else begin
            ev = eq.pop_front();
            chk("outvec", obs, ev);
         end
         cyc++;
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
